sram_access_arbiter: RTL
========================

Name: sram_access_arbiter

Overview:
Shares the single external SRAM port between a pixel-read requester (frame fetch) and a pixel-write requester (result writeback). It grants one access at a time with round-robin priority. It holds address, data and enables stable for a fixed multi-cycle SRAM access window, captures read data at the end of that window, and returns a one-cycle acknowledge to the granted requester. It replaces the free-running read/write timers in the pixel path with a single sequenced access engine.

Parameters:
ADDR_BITS, 16, SRAM address width
DATA_BITS, 24, SRAM data width (one RGB pixel)
ACCESS_CYCLES, 12, clock cycles enables are held per access; legal range 1..255

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
enable  in  1  1 = new grants allowed; 0 = finish in-flight access, then stop granting
rd_req  in  1  read request; held high with rd_addr stable until rd_ack
rd_addr  in  ADDR_BITS  read address
rd_ack  out  1  one-cycle pulse: read complete, rd_data valid
rd_data  out  DATA_BITS  captured read data; holds until next read completes
wr_req  in  1  write request; held high with wr_addr/wr_data stable until wr_ack
wr_addr  in  ADDR_BITS  write address
wr_data  in  DATA_BITS  write data
wr_ack  out  1  one-cycle pulse: write complete
busy  out  1  1 while in READ_ACC, WRITE_ACC or ACK
address  out  ADDR_BITS  SRAM address
w_data  out  DATA_BITS  SRAM write data
r_data  in  DATA_BITS  SRAM read data
read_enable  out  1  SRAM read strobe
write_enable  out  1  SRAM write strobe

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, timer 0, last_grant = WRITE (so read wins first), and all outputs 0 (rd_ack, wr_ack, busy, address, w_data, rd_data, read_enable, write_enable).
- States: IDLE, READ_ACC, WRITE_ACC, ACK.
- IDLE:
  - If enable=1 and exactly one request is high, grant that request.
  - If both are high, grant the side opposite last_grant.
  - On grant: latch address (rd_addr or wr_addr); on a write also latch w_data; set the matching enable to 1; clear timer to 0; update last_grant; go to READ_ACC or WRITE_ACC.
  - With no grant, stay in IDLE with enables 0.
- READ_ACC / WRITE_ACC:
  - read_enable (or write_enable) stays 1, and address and w_data stay constant, for exactly ACCESS_CYCLES cycles.
  - Timer increments every cycle.
  - In the cycle where timer = ACCESS_CYCLES-1:
    - READ_ACC samples r_data into rd_data at the closing edge.
    - Both states drop the enable at that edge and move to ACK.
- ACK:
  - One cycle. The matching rd_ack or wr_ack = 1 and the enables are 0.
  - Next state is IDLE, unconditionally.
  - A requester must update req/addr/data at the edge that ends its ack cycle. IDLE therefore never re-grants a stale request.
- Latency and throughput:
  - Request seen in IDLE at cycle 0, enable high in cycles 1..ACCESS_CYCLES, ack in cycle ACCESS_CYCLES+1.
  - Back-to-back throughput is one access per ACCESS_CYCLES+2 cycles.
- address and w_data hold their last values in IDLE and ACK; they are never driven to Z.
- A request that drops before it is granted is ignored. A request that drops during an access has no effect; the access completes and still acks.
- enable=0:
  - Takes effect only in IDLE.
  - An in-flight access runs to ACK normally.
  - While enable=0, both requests remain pending and no ack is issued.
- Simultaneous requests with a continuous stream on both sides alternate strictly R, W, R, W…
- Asynchronous reset mid-access forces enables and acks to 0 immediately. The aborted access is never acked.
- busy = 1 in READ_ACC, WRITE_ACC and ACK; 0 in IDLE.

Test Plan:
- Single read, ACCESS_CYCLES=12: rd_req=1, rd_addr=0x0010, r_data=0xABCDEF → address=0x0010 and read_enable=1 for exactly 12 cycles, rd_ack pulses 13 cycles after grant, rd_data=0xABCDEF, write_enable never 1.
- Single write: wr_addr=0x0200, wr_data=0x123456 → write_enable=1 for 12 cycles with w_data=0x123456 and address=0x0200 stable, then one wr_ack pulse; changing wr_data mid-access does not alter w_data.
- Contention from reset: rd_req and wr_req both held high, each requester advancing its address on every ack → grant order R, W, R, W; 4 accesses in 4×14=56 cycles; no ack overlap.
- enable deasserted during a read access → that read completes and acks; a pending wr_req is not granted until enable=1 returns.
- n_rst pulsed low in cycle 5 of a write → write_enable=0 asynchronously, no wr_ack, all outputs at reset values; next grant after reset is a read.
- ACCESS_CYCLES=1 build: read at 0x0001 → read_enable high for 1 cycle, rd_ack on the following cycle, 3-cycle turnaround per access.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sram_access_arbiter
//
// Shares one external SRAM port between a pixel-read requester (frame fetch)
// and a pixel-write requester (result writeback). One access at a time is
// granted with round-robin priority. During an access the address, write data
// and the strobe are held stable for ACCESS_CYCLES clocks. Read data is
// captured at the end of that window. The granted requester then gets a
// one-cycle acknowledge.
//
// Parameters
//   ADDR_BITS      SRAM address width
//   DATA_BITS      SRAM data width (one RGB pixel)
//   ACCESS_CYCLES  clocks the strobe is held per access, legal range 1..255
//
// Ports
//   clk, n_rst          clock; asynchronous active-low reset
//   enable              1 = new grants allowed; 0 = finish in-flight, stop
//   rd_req/rd_addr      read request channel
//   rd_ack/rd_data      one-cycle read completion pulse and captured data
//   wr_req/wr_addr/
//   wr_data             write request channel
//   wr_ack              one-cycle write completion pulse
//   busy                1 in READ_ACC, WRITE_ACC and ACK
//   address/w_data/
//   read_enable/
//   write_enable        SRAM-side drive (all registered)
//   r_data              SRAM read data
//
// Handshake: a requester raises req with its address (and write data) stable
// and keeps them stable until its ack pulse. At the clock edge that ends the
// ack cycle, it must drop req or present the next request. The FSM always
// passes through ACK and then IDLE, so a stale request is never re-granted.
// -----------------------------------------------------------------------------
module sram_access_arbiter #(
    parameter int ADDR_BITS     = 16,
    parameter int DATA_BITS     = 24,
    parameter int ACCESS_CYCLES = 12
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 enable,
    input  logic                 rd_req,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_ack,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 wr_req,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_ack,
    output logic                 busy,
    output logic [ADDR_BITS-1:0] address,
    output logic [DATA_BITS-1:0] w_data,
    input  logic [DATA_BITS-1:0] r_data,
    output logic                 read_enable,
    output logic                 write_enable
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_ACC  = 2'd1,
        WRITE_ACC = 2'd2,
        ACK       = 2'd3
    } state_t;

    // last_grant encoding: 0 = read was granted last, 1 = write was granted last.
    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

    // Timer value in the final cycle of the access window.
    localparam logic [7:0] LAST_TICK = 8'(ACCESS_CYCLES - 1);

    state_t               state_q, state_d;
    logic [7:0]           timer_q, timer_d;
    logic                 last_grant_q, last_grant_d;
    logic [ADDR_BITS-1:0] address_q, address_d;
    logic [DATA_BITS-1:0] w_data_q, w_data_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                 read_enable_q, read_enable_d;
    logic                 write_enable_q, write_enable_d;
    logic                 rd_ack_q, rd_ack_d;
    logic                 wr_ack_q, wr_ack_d;
    logic                 busy_q, busy_d;

    logic                 grant_rd;
    logic                 grant_wr;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            timer_q        <= 8'd0;
            last_grant_q   <= GRANT_WR;   // read wins the first contention
            address_q      <= '0;
            w_data_q       <= '0;
            rd_data_q      <= '0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            rd_ack_q       <= 1'b0;
            wr_ack_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            last_grant_q   <= last_grant_d;
            address_q      <= address_d;
            w_data_q       <= w_data_d;
            rd_data_q      <= rd_data_d;
            read_enable_q  <= read_enable_d;
            write_enable_q <= write_enable_d;
            rd_ack_q       <= rd_ack_d;
            wr_ack_q       <= wr_ack_d;
            busy_q         <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Grant decision (only meaningful in IDLE)
    // -------------------------------------------------------------------------
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state_q == IDLE && enable) begin
            if (rd_req && wr_req) begin
                // Contention: serve the side that did not go last.
                grant_rd = (last_grant_q == GRANT_WR);
                grant_wr = (last_grant_q == GRANT_RD);
            end else begin
                grant_rd = rd_req;
                grant_wr = wr_req;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        last_grant_d   = last_grant_q;
        address_d      = address_q;
        w_data_d       = w_data_q;
        rd_data_d      = rd_data_q;
        read_enable_d  = 1'b0;
        write_enable_d = 1'b0;
        rd_ack_d       = 1'b0;
        wr_ack_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    address_d     = rd_addr;
                    read_enable_d = 1'b1;
                    timer_d       = 8'd0;
                    last_grant_d  = GRANT_RD;
                    state_d       = READ_ACC;
                end else if (grant_wr) begin
                    address_d      = wr_addr;
                    w_data_d       = wr_data;
                    write_enable_d = 1'b1;
                    timer_d        = 8'd0;
                    last_grant_d   = GRANT_WR;
                    state_d        = WRITE_ACC;
                end
            end

            READ_ACC: begin
                timer_d = timer_q + 8'd1;
                if (timer_q == LAST_TICK) begin
                    // Closing edge of the window: capture data, drop the strobe.
                    rd_data_d = r_data;
                    rd_ack_d  = 1'b1;
                    state_d   = ACK;
                end else begin
                    read_enable_d = 1'b1;
                end
            end

            WRITE_ACC: begin
                timer_d = timer_q + 8'd1;
                if (timer_q == LAST_TICK) begin
                    wr_ack_d = 1'b1;
                    state_d  = ACK;
                end else begin
                    write_enable_d = 1'b1;
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign rd_ack       = rd_ack_q;
    assign rd_data      = rd_data_q;
    assign wr_ack       = wr_ack_q;
    assign busy         = busy_q;
    assign address      = address_q;
    assign w_data       = w_data_q;
    assign read_enable  = read_enable_q;
    assign write_enable = write_enable_q;

endmodule
